pending_encoder: RTL and testbench

Sequential 16-to-4 priority encoder, the inverse of the team's 4-to-16 enable decoder. It latches one-cycle request pulses on 16 lines into a pending register and offers the index of the highest pending line on a 4-bit code with a valid/ready handshake. On acceptance it clears that line. It sits between event sources (interrupts, per-slot completion strobes) and a consumer that turns the index back into a one-hot select through the decoder.

---
 rtl/pending_encoder_pkg.sv | 23 ++
 rtl/prio_enc16.sv | 34 +++
 rtl/pending_encoder.sv | 96 +++++++++
 tb/tb_pending_encoder.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/pending_encoder_pkg.sv
// Shared constants, FSM state type and helpers for the pending-request encoder.
// Both the top level and the priority finder import this package.
package pending_encoder_pkg;

  localparam int N_REQ = 16;
  localparam int IDX_W = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  // Five-bit result so that all sixteen lines set reports 16 rather than wrapping to 0.
  function automatic logic [4:0] popcount16(input logic [15:0] vec);
    logic [4:0] cnt;
    cnt = '0;
    for (int i = 0; i < 16; i++) begin
      cnt = cnt + {4'b0000, vec[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/prio_enc16.sv
// Combinational highest-set-bit finder for a 16-bit vector.
// Works nibble-wise: each nibble reports its top bit, then the top nonempty nibble wins.
module prio_enc16
  import pending_encoder_pkg::*;
(
  input  logic [N_REQ-1:0] i_vec,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  logic [3:0] w_grp_found;
  logic [1:0] w_loc [4];
  logic [1:0] w_grp;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_nib
      logic [3:0] w_nib;
      assign w_nib          = i_vec[gi*4 +: 4];
      assign w_grp_found[gi] = |w_nib;
      assign w_loc[gi]      = w_nib[3] ? 2'd3 :
                              w_nib[2] ? 2'd2 :
                              w_nib[1] ? 2'd1 : 2'd0;
    end
  endgenerate

  assign w_grp = w_grp_found[3] ? 2'd3 :
                 w_grp_found[2] ? 2'd2 :
                 w_grp_found[1] ? 2'd1 : 2'd0;

  assign found = |w_grp_found;
  assign idx   = {w_grp, w_loc[w_grp]};

endmodule

// File: rtl/pending_encoder.sv
// Latches request pulses into a pending register and offers the highest pending
// line index over a valid/ready handshake, clearing that line on acceptance.
module pending_encoder
  import pending_encoder_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             E,
  input  logic [N_REQ-1:0] req,
  output logic [IDX_W-1:0] a,
  output logic             valid,
  input  logic             ready,
  output logic [N_REQ-1:0] pend,
  output logic [4:0]       pend_cnt,
  output logic             ovf,
  input  logic             ovf_clr
);

  logic [N_REQ-1:0] r_p;
  logic [IDX_W-1:0] r_a;
  logic             r_valid;
  logic             r_ovf;
  state_t           r_state;

  logic [N_REQ-1:0] w_s;
  logic [N_REQ-1:0] w_k;
  logic [N_REQ-1:0] w_p_next;
  logic             w_accept;
  logic             w_ovf_hit;
  logic [IDX_W-1:0] w_top_idx;
  logic             w_found;

  prio_enc16 u_prio (
    .i_vec (r_p),
    .idx   (w_top_idx),
    .found (w_found)
  );

  assign w_s       = req & {N_REQ{E}};
  assign w_accept  = r_valid & ready;
  assign w_k       = w_accept ? (N_REQ'(1) << r_a) : '0;
  // Set wins over clear, so a line re-requested while being acknowledged stays pending.
  assign w_p_next  = (r_p & ~w_k) | w_s;
  assign w_ovf_hit = |(w_s & r_p & ~w_k);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_p   <= '0;
      r_ovf <= 1'b0;
    end else begin
      r_p <= w_p_next;
      if (w_ovf_hit) begin
        r_ovf <= 1'b1;
      end else if (ovf_clr) begin
        r_ovf <= 1'b0;
      end
    end
  end

  // The offer is loaded from the registered P, so a newly captured line is
  // offered one edge after it appears in pend; an accept always passes through IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_a     <= w_top_idx;
            r_valid <= 1'b1;
            r_state <= OFFER;
          end
        end
        OFFER: begin
          if (ready) begin
            r_valid <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign a        = r_a;
  assign valid    = r_valid;
  assign pend     = r_p;
  assign pend_cnt = popcount16(r_p);
  assign ovf      = r_ovf;

endmodule

// File: tb/tb_pending_encoder.sv
// Scoreboard bench for pending_encoder: a cycle-level reference model predicts
// pend/ovf/offers, expected accepted indices are queued and matched by a monitor.
module tb_pending_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        E;
  logic [15:0] req;
  logic        ready;
  logic        ovf_clr;
  logic [3:0]  a;
  logic        valid;
  logic [15:0] pend;
  logic [4:0]  pend_cnt;
  logic        ovf;

  pending_encoder dut (
    .clk      (clk),
    .rst      (rst),
    .E        (E),
    .req      (req),
    .a        (a),
    .valid    (valid),
    .ready    (ready),
    .pend     (pend),
    .pend_cnt (pend_cnt),
    .ovf      (ovf),
    .ovf_clr  (ovf_clr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state: set of pending lines, whether an offer is out, and its index.
  bit [15:0] m_pend  = '0;
  bit        m_offer = 1'b0;
  int        m_a     = 0;
  bit        m_ovf   = 1'b0;
  int        exp_q[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int highest(input bit [15:0] v);
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) return i;
    end
    return -1;
  endfunction

  function automatic int count(input bit [15:0] v);
    int n = 0;
    for (int i = 0; i < 16; i++) n += int'(v[i]);
    return n;
  endfunction

  // One clock of stimulus; the model's next state is committed at the edge.
  task automatic cycle(input bit e, input bit [15:0] r, input bit rdy, input bit clr);
    bit [15:0] n_pend;
    bit        n_offer;
    int        n_a;
    bit        n_ovf;
    bit        accept;
    bit        hit;
    E = e; req = r; ready = rdy; ovf_clr = clr;
    accept  = m_offer && rdy;
    if (accept) exp_q.push_back(m_a);
    hit = 1'b0;
    for (int i = 0; i < 16; i++) begin
      bit s_i, k_i;
      s_i = e && r[i];
      k_i = accept && (i == m_a);
      if (s_i && m_pend[i] && !k_i) hit = 1'b1;
      n_pend[i] = (m_pend[i] && !k_i) || s_i;
    end
    n_ovf   = hit ? 1'b1 : (clr ? 1'b0 : m_ovf);
    n_offer = m_offer;
    n_a     = m_a;
    if (!m_offer) begin
      if (count(m_pend) > 0) begin
        n_offer = 1'b1;
        n_a     = highest(m_pend);
      end
    end else if (accept) begin
      n_offer = 1'b0;
    end
    @(posedge clk);
    m_pend = n_pend; m_offer = n_offer; m_a = n_a; m_ovf = n_ovf;
    #2;
  endtask

  always @(negedge clk) begin
    check("valid", int'(valid), int'(m_offer));
    if (m_offer) check("a_held", int'(a), m_a);
    check("pend", int'(pend), int'(m_pend));
    check("pend_cnt", int'(pend_cnt), count(m_pend));
    check("ovf", int'(ovf), int'(m_ovf));
    if (valid && ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL accept: got a=%0d expected no acceptance at %0t", a, $time);
      end else begin
        check("accept_a", int'(a), exp_q.pop_front());
      end
    end
  end

  task automatic apply_reset();
    rst = 1'b1; req = '0; ready = 1'b0; ovf_clr = 1'b0; E = 1'b0;
    #1;
    m_pend = '0; m_offer = 1'b0; m_a = 0; m_ovf = 1'b0;
    check("rst_valid", int'(valid), 0);
    check("rst_a", int'(a), 0);
    check("rst_pend", int'(pend), 0);
    check("rst_cnt", int'(pend_cnt), 0);
    check("rst_ovf", int'(ovf), 0);
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; E = 1'b0; req = '0; ready = 1'b0; ovf_clr = 1'b0;
    @(posedge clk);
    apply_reset();

    // Single request, consumer always ready.
    cycle(1, 16'h0020, 1, 0);
    for (int i = 0; i < 4; i++) cycle(1, 16'h0000, 1, 0);

    // Two lines at once, consumer stalls, then drains.
    cycle(1, 16'h8001, 0, 0);
    for (int i = 0; i < 5; i++) cycle(1, 16'h0000, 0, 0);
    for (int i = 0; i < 6; i++) cycle(1, 16'h0000, 1, 0);

    // Re-request in the accept cycle keeps the line pending without overflow.
    cycle(1, 16'h0008, 0, 0);
    cycle(1, 16'h0000, 0, 0);
    cycle(1, 16'h0008, 1, 0);
    for (int i = 0; i < 5; i++) cycle(1, 16'h0000, 1, 0);

    // Overflow set, clear, and set-beats-clear.
    cycle(1, 16'h0080, 0, 0);
    cycle(1, 16'h0000, 0, 0);
    cycle(1, 16'h0080, 0, 0);
    cycle(1, 16'h0000, 0, 0);
    cycle(1, 16'h0000, 0, 1);
    cycle(1, 16'h0080, 0, 1);
    cycle(1, 16'h0000, 0, 0);
    cycle(1, 16'h0000, 1, 1);
    for (int i = 0; i < 3; i++) cycle(1, 16'h0000, 1, 0);

    // Capture disabled, then full load drained 15 down to 0.
    cycle(0, 16'hFFFF, 0, 0);
    cycle(0, 16'hFFFF, 1, 0);
    cycle(1, 16'hFFFF, 1, 0);
    for (int i = 0; i < 36; i++) cycle(1, 16'h0000, 1, 0);

    // Asynchronous reset in the middle of an offer, with ovf set.
    cycle(1, 16'h0F00, 0, 0);
    cycle(1, 16'h0100, 0, 0);
    cycle(1, 16'h0000, 0, 0);
    apply_reset();
    cycle(1, 16'h0002, 1, 0);
    for (int i = 0; i < 4; i++) cycle(1, 16'h0000, 1, 0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      bit [15:0] r;
      r = '0;
      if ($urandom_range(0, 2) == 0) r[$urandom_range(0, 15)] = 1'b1;
      if ($urandom_range(0, 9) == 0) r = 16'($urandom);
      cycle($urandom_range(0, 4) != 0, r, $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0);
    end
    for (int i = 0; i < 40; i++) cycle(1, 16'h0000, 1, 1);

    check("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
